// File: rtl/error_responder_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | error_responder_pkg : shared header constants, error codes, FSM states |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package error_responder_pkg;

  localparam int SIZE_OF_HEADER_VARS     = 8;
  localparam int SIZE_OF_HEADER_IN_BYTES = 4;

  localparam logic [7:0] PROTOCOL_VERSION = 8'h01;
  localparam logic [7:0] ERROR_RESP_CMD   = 8'h7F;

  localparam logic [7:0] ERR_INVALID_REQUEST      = 8'h01;
  localparam logic [7:0] ERR_UNSUPPORTED_PROTOCOL = 8'h02;
  localparam logic [7:0] ERR_BUSY                 = 8'h03;
  localparam logic [7:0] ERR_UNSPECIFIED          = 8'h04;

  typedef struct packed {
    logic [7:0] param1;
    logic [7:0] param2;
  } err_code_t;

  // Index 0 sits in the LSBs.
  localparam logic [95:0] DEFAULT_ERR_CODES = {
    err_code_t'{ERR_INVALID_REQUEST,      8'h00},
    err_code_t'{ERR_INVALID_REQUEST,      8'h00},
    err_code_t'{ERR_INVALID_REQUEST,      8'h00},
    err_code_t'{ERR_BUSY,                 8'h00},
    err_code_t'{ERR_UNSUPPORTED_PROTOCOL, 8'h01},
    err_code_t'{ERR_UNSPECIFIED,          8'h00}
  };

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/err_priority_enc.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | err_priority_enc : highest-set-index encoder with any-valid flag        |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module err_priority_enc
  import error_responder_pkg::*;
#(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/error_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | error_responder : sticky error capture, priority pick, ERROR header tx  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module error_responder
  import error_responder_pkg::*;
#(
  parameter int NUM_ERR   = 6,
  parameter int BYTE_W    = SIZE_OF_HEADER_VARS,
  parameter int HDR_BYTES = SIZE_OF_HEADER_IN_BYTES,
  parameter logic [NUM_ERR*2*BYTE_W-1:0] ERR_CODES = DEFAULT_ERR_CODES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_ERR-1:0]          err_req,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [BYTE_W*HDR_BYTES-1:0] header,
  output logic                        msg_busy,
  output logic                        msg_done,
  output logic [NUM_ERR-1:0]          pending,
  output logic [7:0]                  drop_cnt
);

  localparam int EW = (NUM_ERR > 1) ? $clog2(NUM_ERR) : 1;
  localparam int BW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int HW = BYTE_W * HDR_BYTES;
  localparam logic [BW-1:0] LAST_IDX = BW'(HDR_BYTES - 1);

  logic [1:0]         state_q,    state_d;
  logic [NUM_ERR-1:0] pending_q,  pending_d;
  logic [HW-1:0]      header_q,   header_d;
  logic [BYTE_W-1:0]  tx_data_q,  tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               msg_busy_q, msg_busy_d;
  logic               msg_done_q, msg_done_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [BW-1:0]      idx_q,      idx_d;

  logic [EW-1:0]      win;
  logic               win_valid;
  logic               start;
  logic [NUM_ERR-1:0] clr;
  logic [HW-1:0]      hdr_new;
  logic [BW-1:0]      idx_nxt;
  logic [BYTE_W-1:0]  hdr_byte [HDR_BYTES];

  err_priority_enc #(
    .N  (NUM_ERR),
    .IW (EW)
  ) u_prio (
    .req   (pending_q),
    .idx   (win),
    .valid (win_valid)
  );

  // Byte 0 is the most significant byte of the header.
  for (genvar k = 0; k < HDR_BYTES; k++) begin : g_hdr_bytes
    assign hdr_byte[k] = header_q[(HDR_BYTES-1-k)*BYTE_W +: BYTE_W];
  end

  assign idx_nxt = idx_q + 1'b1;
  assign start   = (state_q == ST_IDLE) && enable && win_valid;
  assign clr     = start ? (NUM_ERR'(1) << win) : '0;

  always_comb begin
    hdr_new = '0;
    hdr_new[HW-1 -: 4*BYTE_W] = {PROTOCOL_VERSION, ERROR_RESP_CMD,
                                 ERR_CODES[win*2*BYTE_W +: 2*BYTE_W]};
  end

  always_comb begin
    state_d    = state_q;
    header_d   = header_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    msg_busy_d = msg_busy_q;
    msg_done_d = 1'b0;
    idx_d      = idx_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SEND;
          header_d   = hdr_new;
          tx_data_d  = hdr_new[HW-1 -: BYTE_W];
          tx_valid_d = 1'b1;
          msg_busy_d = 1'b1;
          idx_d      = '0;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            tx_valid_d = 1'b0;
            msg_busy_d = 1'b0;
            msg_done_d = 1'b1;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = hdr_byte[idx_nxt];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        msg_busy_d = 1'b0;
      end
    endcase

    // A request landing on its own clear cycle re-arms the flag, not a drop.
    for (int i = 0; i < NUM_ERR; i++) begin
      if (err_req[i] && pending_q[i] && !clr[i] && (drop_cnt_d != 8'hFF)) begin
        drop_cnt_d = drop_cnt_d + 8'd1;
      end
    end
    pending_d = (pending_q & ~clr) | err_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      header_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      msg_busy_q <= 1'b0;
      msg_done_q <= 1'b0;
      drop_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      header_q   <= header_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      msg_busy_q <= msg_busy_d;
      msg_done_q <= msg_done_d;
      drop_cnt_q <= drop_cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign header   = header_q;
  assign msg_busy = msg_busy_q;
  assign msg_done = msg_done_q;
  assign pending  = pending_q;
  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_error_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_error_responder : directed stimulus with per-cycle reference model   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_error_responder;
  import error_responder_pkg::*;

  localparam int NE = 6;
  localparam int HB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [NE-1:0] err_req;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   header;
  logic          msg_busy;
  logic          msg_done;
  logic [NE-1:0] pending;
  logic [7:0]    drop_cnt;

  error_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .err_req  (err_req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .header   (header),
    .msg_busy (msg_busy),
    .msg_done (msg_done),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting, 1 = sending byte m_idx, 2 = done pulse.
  logic [7:0]    p1_tab [NE] = '{8'h04, 8'h02, 8'h03, 8'h01, 8'h01, 8'h01};
  logic [7:0]    p2_tab [NE] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  int            m_phase = 0;
  int            m_idx   = 0;
  int            m_drop  = 0;
  logic [NE-1:0] m_pend  = '0;
  logic [7:0]    m_hdr [HB] = '{default: 8'h00};

  logic [7:0]    acc_q [$];
  logic [31:0]   done_log [$];
  int            vcnt = 0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data  = 8'h00;

  task automatic model_reset();
    m_phase = 0;
    m_idx   = 0;
    m_drop  = 0;
    m_pend  = '0;
    for (int i = 0; i < HB; i++) m_hdr[i] = 8'h00;
  endtask

  task automatic model_step(input logic en, input logic [NE-1:0] req, input logic rdy);
    logic [NE-1:0] clr;
    int w;
    clr = '0;
    case (m_phase)
      0: if (en && (m_pend != '0)) begin
        w = NE - 1;
        while (!m_pend[w]) w--;
        m_hdr[0] = PROTOCOL_VERSION;
        m_hdr[1] = ERROR_RESP_CMD;
        m_hdr[2] = p1_tab[w];
        m_hdr[3] = p2_tab[w];
        clr[w]   = 1'b1;
        m_phase  = 1;
        m_idx    = 0;
      end
      1: if (rdy) begin
        if (m_idx == HB - 1) m_phase = 2;
        else m_idx++;
      end
      default: m_phase = 0;
    endcase
    for (int i = 0; i < NE; i++)
      if (req[i] && m_pend[i] && !clr[i] && m_drop < 255) m_drop++;
    m_pend = (m_pend & ~clr) | req;
  endtask

  initial begin
    logic          r_en;
    logic [NE-1:0] r_req;
    logic          r_rdy;
    forever begin
      @(posedge clk);
      r_en  = enable;
      r_req = err_req;
      r_rdy = tx_ready;
      if (!rst_n) begin
        model_reset();
      end else begin
        if (s_valid && r_rdy) acc_q.push_back(s_data);
        model_step(r_en, r_req, r_rdy);
      end
      #1;
      chk("tx_valid", tx_valid, m_phase == 1);
      chk("msg_busy", msg_busy, m_phase == 1);
      chk("msg_done", msg_done, m_phase == 2);
      if (m_phase == 1) chk("tx_data", tx_data, m_hdr[m_idx]);
      chk("pending", pending, m_pend);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("header", header, {m_hdr[0], m_hdr[1], m_hdr[2], m_hdr[3]});
      s_valid = tx_valid;
      s_data  = tx_data;
      if (tx_valid) vcnt++;
      if (msg_done) done_log.push_back(header);
    end
  end

  task automatic pulse(input logic [NE-1:0] req);
    @(negedge clk) err_req = req;
    @(negedge clk) err_req = '0;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (tx_valid) ok = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_msg_busy"}, msg_busy, 0);
    chk({tag, "_msg_done"}, msg_done, 0);
    chk({tag, "_pending"},  pending,  0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_header"},   header,   0);
    chk({tag, "_tx_data"},  tx_data,  0);
  endtask

  initial begin
    logic [7:0]  exp_single [4] = '{8'h01, 8'h7F, 8'h03, 8'h00};
    logic [7:0]  exp_bp     [4] = '{8'h01, 8'h7F, 8'h01, 8'h00};
    logic [31:0] exp_pri    [3] = '{32'h017F_0100, 32'h017F_0201, 32'h017F_0400};
    int dsz;
    bit ok;

    rst_n = 1'b0; enable = 1'b0; err_req = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single source, full throughput.
    enable = 1'b1; tx_ready = 1'b1;
    acc_q.delete(); done_log.delete();
    pulse(6'b000100);
    repeat (8) @(negedge clk);
    chk("single_nbytes", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("single_byte", acc_q[i], exp_single[i]);
    chk("single_done", done_log.size(), 1);
    chk("single_pending", pending, 0);

    // Three simultaneous sources come out in priority order.
    acc_q.delete(); done_log.delete();
    pulse(6'b100011);
    repeat (24) @(negedge clk);
    chk("prio_nmsgs", done_log.size(), 3);
    for (int i = 0; i < 3 && i < done_log.size(); i++) chk("prio_header", done_log[i], exp_pri[i]);

    // Alternating back-pressure.
    acc_q.delete(); vcnt = 0;
    pulse(6'b001000);
    repeat (12) begin
      @(negedge clk);
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_nbytes", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("bp_byte", acc_q[i], exp_bp[i]);
    chk("bp_valid_cycles", vcnt, 8);

    // Redundant request while disabled.
    enable = 1'b0;
    pulse(6'b000001);
    pulse(6'b000001);
    @(negedge clk);
    chk("drop_one", drop_cnt, 1);
    chk("drop_pending", pending, 6'b000001);
    chk("gated_valid", tx_valid, 0);

    // Request on its own clear cycle, then enable drops mid-message.
    dsz = done_log.size();
    @(negedge clk) begin enable = 1'b1; err_req = 6'b000001; end
    @(negedge clk) begin enable = 1'b0; err_req = '0; end
    repeat (8) @(negedge clk);
    chk("collide_pending", pending, 6'b000001);
    chk("collide_drop", drop_cnt, 1);
    chk("middis_done", done_log.size(), dsz + 1);
    if (done_log.size() > 0) chk("middis_header", done_log[done_log.size()-1], 32'h017F_0400);

    // Saturation.
    repeat (300) pulse(6'b000001);
    @(negedge clk);
    chk("drop_sat", drop_cnt, 255);

    // Asynchronous reset mid-message.
    dsz = done_log.size();
    enable = 1'b1; tx_ready = 1'b1;
    wait_valid(10, ok);
    chk("rst_wait_valid", ok, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_done", done_log.size(), dsz);
    chk("post_rst_valid", tx_valid, 0);
    chk("post_rst_pending", pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
